// File: rtl/tft_init_sequencer.sv
// TFT panel power-up sequencer: pulses the panel reset, then streams the
// init ROM to the SPI serializer with millisecond pauses at fixed indices.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   start             one-cycle pulse, accepted in IDLE or DONE
//   rom_addr          synchronous ROM address (data returns next cycle)
//   rom_data          ROM word {RS, data[15:0]}
//   spi_valid/ready   handshake towards the serializer
//   spi_rs, spi_data  word being offered, stable while spi_valid is high
//   cs_n, tft_rst_n   panel chip select and hardware reset
//   busy, done        status: sequencing / finished (GRAM-write mode)

module tft_init_sequencer #(
    parameter int unsigned TICK_CYCLES = 100000,
    parameter int unsigned ROM_DEPTH   = 104,
    parameter int unsigned START_IDX   = 1,
    parameter int unsigned RST_LOW_MS  = 10,
    parameter int unsigned RST_WAIT_MS = 50,
    parameter int unsigned D0_IDX      = 11,
    parameter int unsigned D0_MS       = 40,
    parameter int unsigned D1_IDX      = 21,
    parameter int unsigned D1_MS       = 10,
    parameter int unsigned D2_IDX      = 23,
    parameter int unsigned D2_MS       = 50,
    parameter int unsigned D3_IDX      = 87,
    parameter int unsigned D3_MS       = 50
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    output logic [6:0]  rom_addr,
    input  logic [16:0] rom_data,
    output logic        spi_valid,
    output logic        spi_rs,
    output logic [15:0] spi_data,
    input  logic        spi_ready,
    output logic        cs_n,
    output logic        tft_rst_n,
    output logic        busy,
    output logic        done
);

    function automatic int unsigned umax(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MS_MAX =
        umax(umax(umax(RST_LOW_MS, RST_WAIT_MS), umax(D0_MS, D1_MS)),
             umax(D2_MS, D3_MS));
    localparam int unsigned MSW = (MS_MAX < 2) ? 1 : $clog2(MS_MAX + 1);
    localparam int unsigned PW  = (TICK_CYCLES < 2) ? 1
                                                    : $clog2(TICK_CYCLES);

    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [6:0]     LAST_IDX  = 7'(ROM_DEPTH - 1);
    localparam logic [6:0]     FIRST_IDX = 7'(START_IDX);
    localparam logic [MSW-1:0] LOW_MS    = MSW'(RST_LOW_MS);
    localparam logic [MSW-1:0] WAIT_MS   = MSW'(RST_WAIT_MS);

    localparam logic [6:0] D_IDX [4] = '{
        7'(D0_IDX), 7'(D1_IDX), 7'(D2_IDX), 7'(D3_IDX)
    };
    localparam logic [MSW-1:0] D_MS [4] = '{
        MSW'(D0_MS), MSW'(D1_MS), MSW'(D2_MS), MSW'(D3_MS)
    };

    typedef enum logic [2:0] {
        IDLE,
        HW_RST,
        RST_WAIT,
        FETCH,
        LOAD,
        SEND,
        DELAY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      idx_q, idx_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [MSW-1:0]  ms_q, ms_d;
    logic [MSW-1:0]  dly_q, dly_d;
    logic [3:0]      served_q, served_d;
    logic            spi_valid_q, spi_valid_d;
    logic            spi_rs_q, spi_rs_d;
    logic [15:0]     spi_data_q, spi_data_d;
    logic            cs_n_q, cs_n_d;
    logic            tft_rst_n_q, tft_rst_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            timed;
    logic            tick;
    logic            ms_end;
    logic [MSW-1:0]  target;
    logic [MSW:0]    ms_nx;
    logic            hit;
    logic [1:0]      hit_k;
    logic [MSW-1:0]  hit_ms;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pre_d       = pre_q;
        ms_d        = ms_q;
        dly_d       = dly_q;
        served_d    = served_q;
        spi_valid_d = spi_valid_q;
        spi_rs_d    = spi_rs_q;
        spi_data_d  = spi_data_q;
        cs_n_d      = cs_n_q;

        timed = (state_q == HW_RST) || (state_q == RST_WAIT) ||
                (state_q == DELAY);
        tick  = timed && (pre_q == TICK_LAST);

        unique case (state_q)
            HW_RST:   target = LOW_MS;
            RST_WAIT: target = WAIT_MS;
            DELAY:    target = dly_q;
            default:  target = '0;
        endcase

        // Last tick of the state: this tick completes the N-th ms.
        ms_nx  = {1'b0, ms_q} + {{MSW{1'b0}}, 1'b1};
        ms_end = tick && (ms_nx >= {1'b0, target});

        // First enabled, not yet served delay at this index wins.
        hit    = 1'b0;
        hit_k  = 2'd0;
        hit_ms = '0;
        for (int k = 0; k < 4; k++) begin
            if (!hit && idx_q == D_IDX[k] && D_MS[k] != '0 &&
                !served_q[k]) begin
                hit    = 1'b1;
                hit_k  = 2'(k);
                hit_ms = D_MS[k];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) state_d = HW_RST;
            end
            HW_RST: begin
                if (ms_end) state_d = RST_WAIT;
            end
            RST_WAIT: begin
                if (ms_end) begin
                    state_d = FETCH;
                    idx_d   = FIRST_IDX;
                end
            end
            FETCH: begin
                if (hit) begin
                    state_d         = DELAY;
                    served_d[hit_k] = 1'b1;
                    dly_d           = hit_ms;
                end else begin
                    state_d  = LOAD;
                    served_d = '0;
                end
            end
            LOAD: begin
                spi_rs_d    = rom_data[16];
                spi_data_d  = rom_data[15:0];
                spi_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (spi_ready) begin
                    spi_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = FETCH;
                    end
                end
            end
            DELAY: begin
                if (ms_end) state_d = FETCH;
            end
            DONE: begin
                if (start) state_d = HW_RST;
            end
            default: state_d = IDLE;
        endcase

        // Timebase restarts on every state entry.
        if (state_d != state_q) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (timed) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            ms_d  = tick ? ms_q + MSW'(1) : ms_q;
        end

        // cs_n drops with the first SEND and rises only for resets/pauses.
        unique case (state_d)
            HW_RST, DELAY: cs_n_d = 1'b1;
            SEND, DONE:    cs_n_d = 1'b0;
            default:       cs_n_d = cs_n_q;
        endcase

        tft_rst_n_d = (state_d != HW_RST);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pre_q       <= '0;
            ms_q        <= '0;
            dly_q       <= '0;
            served_q    <= '0;
            spi_valid_q <= 1'b0;
            spi_rs_q    <= 1'b0;
            spi_data_q  <= '0;
            cs_n_q      <= 1'b1;
            tft_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pre_q       <= pre_d;
            ms_q        <= ms_d;
            dly_q       <= dly_d;
            served_q    <= served_d;
            spi_valid_q <= spi_valid_d;
            spi_rs_q    <= spi_rs_d;
            spi_data_q  <= spi_data_d;
            cs_n_q      <= cs_n_d;
            tft_rst_n_q <= tft_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = idx_q;
    assign spi_valid = spi_valid_q;
    assign spi_rs    = spi_rs_q;
    assign spi_data  = spi_data_q;
    assign cs_n      = cs_n_q;
    assign tft_rst_n = tft_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tft_init_sequencer.sv
// Testbench for tft_init_sequencer: scoreboarded ROM stream on two
// instances (default delays and D1 disabled) with directed timing checks.

module tb_tft_init_sequencer;

    localparam int TC = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic        start_v [2];
    logic        ready_v [2];
    logic [6:0]  addr_v  [2];
    logic [16:0] rom_v   [2];
    logic        valid_v [2];
    logic        rs_v    [2];
    logic [15:0] data_v  [2];
    logic        csn_v   [2];
    logic        trst_v  [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    tft_init_sequencer #(
        .TICK_CYCLES(TC),
        .RST_LOW_MS (2)
    ) u_dut0 (
        .CLK      (CLK),
        .RST_N    (rst_n),
        .start    (start_v[0]),
        .rom_addr (addr_v[0]),
        .rom_data (rom_v[0]),
        .spi_valid(valid_v[0]),
        .spi_rs   (rs_v[0]),
        .spi_data (data_v[0]),
        .spi_ready(ready_v[0]),
        .cs_n     (csn_v[0]),
        .tft_rst_n(trst_v[0]),
        .busy     (busy_v[0]),
        .done     (done_v[0])
    );

    tft_init_sequencer #(
        .TICK_CYCLES(TC),
        .RST_LOW_MS (2),
        .D1_MS      (0)
    ) u_dut1 (
        .CLK      (CLK),
        .RST_N    (rst_n),
        .start    (start_v[1]),
        .rom_addr (addr_v[1]),
        .rom_data (rom_v[1]),
        .spi_valid(valid_v[1]),
        .spi_rs   (rs_v[1]),
        .spi_data (data_v[1]),
        .spi_ready(ready_v[1]),
        .cs_n     (csn_v[1]),
        .tft_rst_n(trst_v[1]),
        .busy     (busy_v[1]),
        .done     (done_v[1])
    );

    // Init ROM image; idx 1 and 103 carry the fixed first/last words.
    function automatic logic [16:0] rom_word(input logic [6:0] a);
        logic [7:0] b;
        b = {1'b0, a};
        case (a)
            7'd1:    return 17'h00010;
            7'd103:  return 17'h00022;
            default: return {a[0], b ^ 8'h5A, b};
        endcase
    endfunction

    always @(posedge CLK) begin
        rom_v[0] <= rom_word(addr_v[0]);
        rom_v[1] <= rom_word(addr_v[1]);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [16:0] word;
        logic [6:0]  idx;
        int          gap;
        bit          chk_gap;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    int   word_cnt [2] = '{0, 0};
    int   gap_cnt  [2] = '{0, 0};

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // cs_n-high cycles expected before word i: DELAY plus FETCH and LOAD.
    function automatic int gap_for(input int i, input int d1);
        case (i)
            11:      return 40 * TC + 2;
            21:      return (d1 > 0) ? d1 * TC + 2 : 0;
            23, 87:  return 50 * TC + 2;
            default: return 0;
        endcase
    endfunction

    task automatic push_run(input int k, input int d1);
        exp_t e;
        for (int i = 1; i <= 103; i++) begin
            e.word    = rom_word(7'(i));
            e.idx     = 7'(i);
            e.gap     = gap_for(i, d1);
            e.chk_gap = (i > 1);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge CLK) begin
            exp_t e;
            if (!rst_n) begin
                gap_cnt[g] = 0;
            end else if (valid_v[g] && ready_v[g]) begin
                if (q_size(g) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d extra word: got %05h expected none",
                             g, {rs_v[g], data_v[g]});
                end else begin
                    e = pop_exp(g);
                    check($sformatf("dut%0d word idx%0d", g, e.idx),
                          32'({rs_v[g], data_v[g]}), 32'(e.word));
                    check($sformatf("dut%0d rom_addr idx%0d", g, e.idx),
                          32'(addr_v[g]), 32'(e.idx));
                    if (e.chk_gap)
                        check($sformatf("dut%0d cs_n gap idx%0d", g, e.idx),
                              gap_cnt[g], e.gap);
                end
                word_cnt[g] = word_cnt[g] + 1;
                gap_cnt[g]  = 0;
            end else if (csn_v[g]) begin
                gap_cnt[g] = gap_cnt[g] + 1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, " spi_valid"}, 32'(valid_v[k]), 0);
        check({tag, " spi_rs"},    32'(rs_v[k]),    0);
        check({tag, " spi_data"},  32'(data_v[k]),  0);
        check({tag, " rom_addr"},  32'(addr_v[k]),  0);
        check({tag, " cs_n"},      32'(csn_v[k]),   1);
        check({tag, " tft_rst_n"}, 32'(trst_v[k]),  1);
        check({tag, " busy"},      32'(busy_v[k]),  0);
        check({tag, " done"},      32'(done_v[k]),  0);
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (!done_v[k] && n < 8000) begin
            step();
            n++;
        end
        check({tag, " reached done"}, 32'(done_v[k]), 1);
    endtask

    initial begin
        int n;
        int base;
        rst_n      = 1'b0;
        start_v    = '{1'b0, 1'b0};
        ready_v    = '{1'b1, 1'b1};
        repeat (3) step();
        check_reset(0, "por");
        rst_n = 1'b1;
        step();

        // Run 1: reset pulse timing, stall, ignored start, full stream.
        push_run(0, 10);
        base = word_cnt[0];
        pulse_start(0);
        n = 0;
        while (!trst_v[0] && n < 100) begin
            step();
            n++;
        end
        check("tft_rst_n low cycles", n, 8);
        n = 0;
        while (!valid_v[0] && n < 1000) begin
            step();
            n++;
        end
        // RST_WAIT (50 ms * 4) followed by the first FETCH and LOAD.
        check("rst release to first valid", n, 202);
        check("first word", 32'({rs_v[0], data_v[0]}), 32'h00010);

        n = 0;
        while (!(addr_v[0] == 7'd5 && !valid_v[0]) && n < 100) begin
            step();
            n++;
        end
        ready_v[0] = 1'b0;
        n = 0;
        while (!valid_v[0] && n < 10) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall valid", 32'(valid_v[0]), 1);
            check("stall word", 32'({rs_v[0], data_v[0]}), 32'h15F05);
            check("stall addr", 32'(addr_v[0]), 5);
        end
        ready_v[0] = 1'b1;
        step();
        check("valid drops after transfer", 32'(valid_v[0]), 0);
        check("index advanced", 32'(addr_v[0]), 6);

        n = 0;
        while (addr_v[0] != 7'd30 && n < 2000) begin
            step();
            n++;
        end
        pulse_start(0);
        check("start while busy: tft_rst_n", 32'(trst_v[0]), 1);
        check("start while busy: busy", 32'(busy_v[0]), 1);

        wait_done(0, "run1");
        check("run1 word count", word_cnt[0] - base, 103);
        check("run1 queue empty", q0.size(), 0);
        check("done cs_n", 32'(csn_v[0]), 0);
        check("done busy", 32'(busy_v[0]), 0);
        check("done spi_valid", 32'(valid_v[0]), 0);

        // Run 2: reset in the middle of the idx 11 pause.
        push_run(0, 10);
        pulse_start(0);
        n = 0;
        while (!(addr_v[0] == 7'd11 && csn_v[0] && busy_v[0]) && n < 2000) begin
            step();
            n++;
        end
        check("reached delay 11", 32'(csn_v[0] && busy_v[0]), 1);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check_reset(0, "mid-delay");
        q0.delete();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("no restart without start", 32'(busy_v[0]), 0);
        push_run(0, 10);
        base = word_cnt[0];
        pulse_start(0);
        check("restart enters HW_RST", 32'(trst_v[0]), 0);
        wait_done(0, "run2");
        check("run2 word count", word_cnt[0] - base, 103);

        // Instance with D1 disabled, then a restart from DONE.
        push_run(1, 0);
        base = word_cnt[1];
        pulse_start(1);
        wait_done(1, "d1off");
        check("d1off word count", word_cnt[1] - base, 103);
        push_run(1, 0);
        base = word_cnt[1];
        pulse_start(1);
        check("rerun clears done", 32'(done_v[1]), 0);
        check("rerun busy", 32'(busy_v[1]), 1);
        wait_done(1, "rerun");
        check("rerun word count", word_cnt[1] - base, 103);
        check("rerun queue empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
